vortex_axil_ctrl_master: RTL and testbench
==========================================

// Module: vortex_axil_ctrl_master
// PURPOSE
//  AXI4-Lite master that drives the AFU control slave port (s_axi_ctrl_*) from a simple command/response interface.
//  Sits on the host/shell side: testbench host model, or on-chip debug or bring-up logic issuing control register accesses.
//  One outstanding transaction. Every transaction ends in exactly one response; a timeout guards against a hung slave.
// PARAMETERS
//  ADDR_WIDTH      8     AXI-Lite address width (matches the control slave)
//  DATA_WIDTH      32    AXI-Lite data width; 32 or 64
//  TIMEOUT_CYCLES  1024  cycles from command accept to forced completion; 0 disables the timeout
// PORTS
//  ap_clk              in   1             clock
//  ap_rst_n            in   1             async reset, active-low
//  cmd_valid           in   1             command request
//  cmd_ready           out  1             command accepted when valid&ready
//  cmd_write           in   1             1=write, 0=read
//  cmd_addr            in   ADDR_WIDTH    byte address
//  cmd_data            in   DATA_WIDTH    write data
//  cmd_strb            in   DATA_WIDTH/8  write byte strobes
//  rsp_valid           out  1             response valid
//  rsp_ready           in   1             response consumed when valid&ready
//  rsp_data            out  DATA_WIDTH    read data; 0 for writes and timeouts
//  rsp_resp            out  2             AXI resp code (BRESP/RRESP); 2'b10 on timeout
//  rsp_timeout         out  1             1 = transaction forced-completed by timeout
//  busy                out  1             high whenever not IDLE
//  m_axi_ctrl_awvalid/awready/awaddr  out/in/out  1/1/ADDR_WIDTH   write address channel
//  m_axi_ctrl_wvalid/wready/wdata/wstrb  out/in/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8  write data channel
//  m_axi_ctrl_bvalid/bready/bresp     in/out/in   1/1/2            write response channel
//  m_axi_ctrl_arvalid/arready/araddr  out/in/out  1/1/ADDR_WIDTH   read address channel
//  m_axi_ctrl_rvalid/rready/rdata/rresp  in/out/in/in  1/1/DATA_WIDTH/2  read data channel
// BEHAVIOUR
//  Reset (ap_rst_n low, async): state=IDLE; all outputs 0, except cmd_ready=1 after reset is released; timeout counter 0.
//  FSM: IDLE -> WR (aw/w) -> WR_B -> RSP -> IDLE.  IDLE -> RD_A -> RD_D -> RSP -> IDLE.
//  IDLE: cmd_ready=1. On cmd_valid, latch cmd_*.
//   - Force the low log2(DATA_WIDTH/8) address bits to 0.
//   - Next cycle enter WR or RD_A.
//  WR: awvalid and wvalid are both asserted on the first WR cycle.
//   - Each drops on its own handshake; aw and w complete independently, in either order or in the same cycle.
//   - Once both have completed, go to WR_B. The transition happens the cycle after the later handshake.
//  WR_B: bready=1. On bvalid, capture bresp and set rsp_data=0; go to RSP.
//  RD_A: arvalid=1 until arready, then RD_D.
//  RD_D: rready=1. On rvalid, capture rdata/rresp; go to RSP.
//  RSP: rsp_valid=1, held stable until rsp_ready; then IDLE.
//   - The next command is accepted no earlier than the cycle after rsp handshake (cmd_ready is 0 outside IDLE).
//  Valid/data stability: awaddr, wdata, wstrb and araddr are held stable while the matching valid is high.
//   - No valid depends combinationally on any ready.
//  Min latency (zero-wait slave): cmd accept at T0; aw/w/ar valid at T1; b/r handshake no earlier than T2; rsp_valid at T3.
//  Timeout:
//   - Counter clears on cmd accept and increments every cycle outside IDLE and RSP.
//   - When it reaches TIMEOUT_CYCLES-1, the FSM goes to RSP instead of the normal next state.
//   - On that transition all m_axi valids and readies drop, rsp_timeout=1, rsp_resp=2'b10, rsp_data=0.
//   - A handshake that completes in the timeout cycle takes precedence: normal response, rsp_timeout=0.
//   - Timeout abandons the slave transaction; the caller must reset the slave before reuse.
//  rsp_resp from the slave is passed through unmodified; SLVERR/DECERR are not retried.
//  Stray bvalid/rvalid outside WR_B/RD_D is ignored (bready/rready=0).
// TESTING
//  1 Write 0x00<=0x1, strb 0xF, zero-wait slave -> aw&w valid at T1, rsp_valid at T3, rsp_resp=0, rsp_data=0.
//  2 Read 0x10, slave returns 0xDEADBEEF after 3 stall cycles -> rsp_data=0xDEADBEEF, resp=0, arvalid held until arready.
//  3 Write where wready comes 4 cycles before awready, and a second write where awready&wready come in the same cycle
//    -> exactly one aw and one w beat each; bready asserts only after both.
//  4 rsp_ready low for 5 cycles, cmd_valid held high -> rsp stable, cmd_ready=0, next command accepted one cycle after rsp handshake.
//  5 TIMEOUT_CYCLES=16, slave never asserts bvalid -> rsp_valid 16 cycles after accept, rsp_timeout=1, resp=2'b10, bready dropped.
//  6 ap_rst_n pulsed low during RD_D -> all outputs 0 immediately; after release cmd_ready=1 and a new read completes normally.

Source files
------------

// File: rtl/vortex_axil_ctrl_master.sv
// AXI4-Lite master: turns one command/response transaction at a time into
// AXI-Lite control-port accesses, with a cycle timeout against a hung slave.
module vortex_axil_ctrl_master #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_data,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    output logic                    busy,

    output logic                    m_axi_ctrl_awvalid,
    input  logic                    m_axi_ctrl_awready,
    output logic [ADDR_WIDTH-1:0]   m_axi_ctrl_awaddr,
    output logic                    m_axi_ctrl_wvalid,
    input  logic                    m_axi_ctrl_wready,
    output logic [DATA_WIDTH-1:0]   m_axi_ctrl_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_ctrl_wstrb,
    input  logic                    m_axi_ctrl_bvalid,
    output logic                    m_axi_ctrl_bready,
    input  logic [1:0]              m_axi_ctrl_bresp,
    output logic                    m_axi_ctrl_arvalid,
    input  logic                    m_axi_ctrl_arready,
    output logic [ADDR_WIDTH-1:0]   m_axi_ctrl_araddr,
    input  logic                    m_axi_ctrl_rvalid,
    output logic                    m_axi_ctrl_rready,
    input  logic [DATA_WIDTH-1:0]   m_axi_ctrl_rdata,
    input  logic [1:0]              m_axi_ctrl_rresp
);

    localparam int unsigned StrbW = DATA_WIDTH / 8;
    localparam int unsigned LsbW  = $clog2(StrbW);
    localparam int unsigned CntW  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {StIdle, StWr, StWrB, StRdA, StRdD, StRsp} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [StrbW-1:0]      wstrb_q, wstrb_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  timeout_hit;

    // Fires in the cycle whose increment brings the count to TIMEOUT_CYCLES-1.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         ((32'(cnt_q) + 32'd1) >= (TIMEOUT_CYCLES - 32'd1));

    assign cmd_ready          = (state_q == StIdle) && ap_rst_n;
    assign busy               = (state_q != StIdle);
    assign rsp_valid          = (state_q == StRsp);
    assign rsp_data           = rsp_data_q;
    assign rsp_resp           = rsp_resp_q;
    assign rsp_timeout        = rsp_timeout_q;
    assign m_axi_ctrl_awvalid = (state_q == StWr) && !aw_done_q;
    assign m_axi_ctrl_wvalid  = (state_q == StWr) && !w_done_q;
    assign m_axi_ctrl_bready  = (state_q == StWrB);
    assign m_axi_ctrl_arvalid = (state_q == StRdA);
    assign m_axi_ctrl_rready  = (state_q == StRdD);
    assign m_axi_ctrl_awaddr  = addr_q;
    assign m_axi_ctrl_araddr  = addr_q;
    assign m_axi_ctrl_wdata   = wdata_q;
    assign m_axi_ctrl_wstrb   = wstrb_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        rsp_data_d    = rsp_data_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;

        if (state_q != StIdle && state_q != StRsp) begin
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    addr_d             = cmd_addr;
                    addr_d[LsbW-1:0]   = '0;
                    wdata_d            = cmd_data;
                    wstrb_d            = cmd_strb;
                    aw_done_d          = 1'b0;
                    w_done_d           = 1'b0;
                    rsp_timeout_d      = 1'b0;
                    cnt_d              = '0;
                    state_d            = cmd_write ? StWr : StRdA;
                end
            end
            StWr: begin
                if (m_axi_ctrl_awvalid && m_axi_ctrl_awready) aw_done_d = 1'b1;
                if (m_axi_ctrl_wvalid && m_axi_ctrl_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = StWrB;
                else if (timeout_hit)      state_d = StRsp;
            end
            StWrB: begin
                if (m_axi_ctrl_bvalid) begin
                    rsp_resp_d = m_axi_ctrl_bresp;
                    rsp_data_d = '0;
                    state_d    = StRsp;
                end else if (timeout_hit) begin
                    state_d = StRsp;
                end
            end
            StRdA: begin
                if (m_axi_ctrl_arready)  state_d = StRdD;
                else if (timeout_hit)    state_d = StRsp;
            end
            StRdD: begin
                if (m_axi_ctrl_rvalid) begin
                    rsp_resp_d = m_axi_ctrl_rresp;
                    rsp_data_d = m_axi_ctrl_rdata;
                    state_d    = StRsp;
                end else if (timeout_hit) begin
                    state_d = StRsp;
                end
            end
            StRsp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A timeout exit is any jump to RSP that no handshake produced.
        if (state_q != StRsp && state_q != StIdle && state_d == StRsp &&
            !(state_q == StWrB && m_axi_ctrl_bvalid) &&
            !(state_q == StRdD && m_axi_ctrl_rvalid)) begin
            rsp_timeout_d = 1'b1;
            rsp_resp_d    = 2'b10;
            rsp_data_d    = '0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            rsp_data_q    <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            rsp_data_q    <= rsp_data_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

endmodule

// File: tb/tb_vortex_axil_ctrl_master.sv
// Directed and randomized checks of vortex_axil_ctrl_master against a word-memory
// reference model and a configurable-stall AXI-Lite slave.
module tb_vortex_axil_ctrl_master;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [7:0]  awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    vortex_axil_ctrl_master #(
        .ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
        .m_axi_ctrl_awvalid(awvalid), .m_axi_ctrl_awready(awready),
        .m_axi_ctrl_awaddr(awaddr),
        .m_axi_ctrl_wvalid(wvalid), .m_axi_ctrl_wready(wready),
        .m_axi_ctrl_wdata(wdata), .m_axi_ctrl_wstrb(wstrb),
        .m_axi_ctrl_bvalid(bvalid), .m_axi_ctrl_bready(bready),
        .m_axi_ctrl_bresp(bresp),
        .m_axi_ctrl_arvalid(arvalid), .m_axi_ctrl_arready(arready),
        .m_axi_ctrl_araddr(araddr),
        .m_axi_ctrl_rvalid(rvalid), .m_axi_ctrl_rready(rready),
        .m_axi_ctrl_rdata(rdata), .m_axi_ctrl_rresp(rresp)
    );

    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    int n_pass = 0, n_total = 0, n_fail = 0;

    // Slave configuration and per-transaction observations.
    int aw_d = 0, w_d = 0, b_d = 0, ar_d = 0, r_d = 0;
    logic [1:0] cfg_resp = 2'b00;
    logic [31:0] smem [64];
    logic [31:0] rmem [64];
    int b_cnt = -1, r_cnt = -1, aw_wait = 0, w_wait = 0, ar_wait = 0;
    bit got_aw = 0, got_w = 0;
    logic [7:0]  aw_rec, ar_rec, aw_hold, ar_hold;
    logic [31:0] wd_rec, wd_hold;
    logic [3:0]  ws_rec, ws_hold;
    int aw_beats, w_beats, ar_beats, aw_vc, w_vc, ar_vc;
    int aw_first, w_first, b_first, aw_hs, w_hs;
    int stab_err = 0;

    int acc_cyc, lat;
    logic [31:0] o_data;
    logic [1:0]  o_resp;
    logic        o_to, o_bready, o_rready, o_busy, o_cmdrdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_track();
        aw_beats = 0; w_beats = 0; ar_beats = 0; aw_vc = 0; w_vc = 0; ar_vc = 0;
        aw_first = -1; w_first = -1; b_first = -1; aw_hs = -1; w_hs = -1;
    endtask

    task automatic set_delays(input int a, input int w, input int b, input int ar, input int r);
        aw_d = a; w_d = w; b_d = b; ar_d = ar; r_d = r;
    endtask

    task automatic send_cmd(input bit wr, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        int guard = 0;
        clr_track();
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_data = d; cmd_strb = s;
        while (!cmd_ready && guard < 100) begin @(negedge ap_clk); guard++; end
        chk("cmd_accept", cmd_ready, 1);
        acc_cyc = cyc;
        @(negedge ap_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int guard = 0;
        while (!rsp_valid && guard < 200) begin @(negedge ap_clk); guard++; end
        chk("rsp_wait", rsp_valid, 1);
        lat = cyc - acc_cyc;
        o_data = rsp_data; o_resp = rsp_resp; o_to = rsp_timeout;
        o_bready = bready; o_rready = rready; o_busy = busy; o_cmdrdy = cmd_ready;
        rsp_ready = 1'b1;
        @(negedge ap_clk);
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
    endtask

    task automatic ref_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) rmem[a[7:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    // Slave: response channels are handled before request channels so a request
    // accepted in a cycle gets its response no earlier than the following cycle.
    initial begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                bresp = 0; rresp = 0; rdata = 0;
                b_cnt = -1; r_cnt = -1; got_aw = 0; got_w = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0;
            end else begin
                if (bready && b_first < 0) b_first = cyc;
                if (b_cnt == 0) begin bvalid = 1; bresp = cfg_resp; end
                else begin bvalid = 0; bresp = 0; if (b_cnt > 0) b_cnt--; end
                if (bvalid && bready) b_cnt = -1;

                if (r_cnt == 0) begin
                    rvalid = 1; rresp = cfg_resp; rdata = smem[ar_rec[7:2]];
                end else begin
                    rvalid = 0; rresp = 0; rdata = 0; if (r_cnt > 0) r_cnt--;
                end
                if (rvalid && rready) r_cnt = -1;

                awready = 0;
                if (awvalid) begin
                    if (aw_first < 0) aw_first = cyc;
                    aw_vc++;
                    if (aw_wait > 0 && awaddr !== aw_hold) stab_err++;
                    aw_hold = awaddr;
                    if (aw_wait >= aw_d) begin
                        awready = 1; aw_wait = 0; aw_beats++; got_aw = 1;
                        aw_rec = awaddr; aw_hs = cyc;
                    end else aw_wait++;
                end
                wready = 0;
                if (wvalid) begin
                    if (w_first < 0) w_first = cyc;
                    w_vc++;
                    if (w_wait > 0 && (wdata !== wd_hold || wstrb !== ws_hold)) stab_err++;
                    wd_hold = wdata; ws_hold = wstrb;
                    if (w_wait >= w_d) begin
                        wready = 1; w_wait = 0; w_beats++; got_w = 1;
                        wd_rec = wdata; ws_rec = wstrb; w_hs = cyc;
                    end else w_wait++;
                end
                if (got_aw && got_w) begin
                    for (int b = 0; b < 4; b++)
                        if (ws_rec[b]) smem[aw_rec[7:2]][8*b +: 8] = wd_rec[8*b +: 8];
                    got_aw = 0; got_w = 0; b_cnt = b_d;
                end
                arready = 0;
                if (arvalid) begin
                    ar_vc++;
                    if (ar_wait > 0 && araddr !== ar_hold) stab_err++;
                    ar_hold = araddr;
                    if (ar_wait >= ar_d) begin
                        arready = 1; ar_wait = 0; ar_beats++; ar_rec = araddr; r_cnt = r_d;
                    end else ar_wait++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] hold;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        bit          wr;
        int          mx;

        for (int i = 0; i < 64; i++) begin smem[i] = $urandom; rmem[i] = smem[i]; end
        ap_rst_n = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_data = 0;
        cmd_strb = 0; rsp_ready = 0;
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_outputs", {rsp_valid, busy, awvalid, wvalid, bready, arvalid, rready,
                            rsp_timeout}, 0);
        chk("rst_rsp_data", rsp_data, 0);
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
        chk("rel_cmd_ready", cmd_ready, 1);
        chk("rel_busy", busy, 0);
        @(negedge ap_clk);

        // Zero-wait write.
        set_delays(0, 0, 0, 0, 0); cfg_resp = 2'b00;
        send_cmd(1, 8'h00, 32'h1, 4'hF); ref_write(8'h00, 32'h1, 4'hF);
        wait_rsp();
        chk("t1_aw_T1", aw_first - acc_cyc, 1);
        chk("t1_w_T1", w_first - acc_cyc, 1);
        chk("t1_lat", lat, 3);
        chk("t1_resp", o_resp, 0);
        chk("t1_data", o_data, 0);
        chk("t1_smem", smem[0], rmem[0]);

        // Read with arready stalled three cycles; low address bits are dropped.
        smem[4] = 32'hDEADBEEF; rmem[4] = 32'hDEADBEEF;
        set_delays(0, 0, 0, 3, 0);
        send_cmd(0, 8'h13, 32'h0, 4'h0);
        wait_rsp();
        chk("t2_data", o_data, 32'hDEADBEEF);
        chk("t2_resp", o_resp, 0);
        chk("t2_ar_cycles", ar_vc, 4);
        chk("t2_araddr", ar_rec, 8'h10);
        chk("t2_lat", lat, 6);

        // W completes four cycles before AW, then both in the same stalled cycle.
        set_delays(4, 0, 0, 0, 0);
        send_cmd(1, 8'h08, 32'hA5A5_0F0F, 4'h5); ref_write(8'h08, 32'hA5A5_0F0F, 4'h5);
        wait_rsp();
        chk("t3a_beats", {aw_beats[7:0], w_beats[7:0]}, 16'h0101);
        chk("t3a_w_cycles", w_vc, 1);
        chk("t3a_bready", b_first, aw_hs + 1);
        chk("t3a_lat", lat, 7);
        chk("t3a_smem", smem[2], rmem[2]);
        set_delays(2, 2, 0, 0, 0);
        send_cmd(1, 8'h0C, 32'h1234_5678, 4'hF); ref_write(8'h0C, 32'h1234_5678, 4'hF);
        wait_rsp();
        chk("t3b_beats", {aw_beats[7:0], w_beats[7:0]}, 16'h0101);
        chk("t3b_same_cycle", aw_hs, w_hs);
        chk("t3b_bready", b_first, aw_hs + 1);
        chk("t3b_lat", lat, 5);

        // Back-pressured response with the next command already waiting.
        set_delays(0, 0, 0, 1, 1);
        clr_track();
        cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h20; cmd_data = 0; cmd_strb = 0;
        @(negedge ap_clk);
        cmd_addr = 8'h24;
        begin
            int g = 0;
            while (!rsp_valid && g < 100) begin @(negedge ap_clk); g++; end
        end
        chk("t4_rsp_valid", rsp_valid, 1);
        hold = rsp_data;
        chk("t4_data", hold, rmem[8]);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", rsp_valid, 1);
            chk("t4_hold_data", rsp_data, hold);
            chk("t4_cmd_ready_low", cmd_ready, 0);
            @(negedge ap_clk);
        end
        rsp_ready = 1;
        chk("t4_cmd_ready_hs", cmd_ready, 0);
        @(negedge ap_clk);
        rsp_ready = 0;
        chk("t4_next_accept", cmd_ready, 1);
        acc_cyc = cyc;
        @(negedge ap_clk);
        cmd_valid = 0;
        chk("t4_busy", busy, 1);
        wait_rsp();
        chk("t4_next_data", o_data, rmem[9]);
        chk("t4_next_lat", lat, 5);

        // Timeout with no B response, and the boundary where B lands just in time.
        set_delays(0, 0, 1000, 0, 0);
        send_cmd(1, 8'hF0, 32'h0, 4'hF);
        wait_rsp();
        chk("t5_lat", lat, 16);
        chk("t5_timeout", o_to, 1);
        chk("t5_resp", o_resp, 2'b10);
        chk("t5_data", o_data, 0);
        chk("t5_bready", o_bready, 0);
        do_reset();
        set_delays(0, 0, 13, 0, 0); cfg_resp = 2'b01;
        send_cmd(1, 8'hF4, 32'h0, 4'hF);
        wait_rsp();
        chk("t5_edge_lat", lat, 16);
        chk("t5_edge_timeout", o_to, 0);
        chk("t5_edge_resp", o_resp, 2'b01);
        set_delays(0, 0, 14, 0, 0);
        send_cmd(1, 8'hF8, 32'h0, 4'hF);
        wait_rsp();
        chk("t5_late_lat", lat, 16);
        chk("t5_late_timeout", o_to, 1);
        chk("t5_late_resp", o_resp, 2'b10);
        do_reset();
        set_delays(0, 0, 0, 20, 0);
        send_cmd(0, 8'hFC, 32'h0, 4'h0);
        wait_rsp();
        chk("t5_rd_lat", lat, 16);
        chk("t5_rd_timeout", {o_to, o_rready, arvalid}, 3'b100);
        do_reset();
        cfg_resp = 2'b00;

        // Reset asserted while waiting for read data.
        set_delays(0, 0, 0, 0, 40);
        send_cmd(0, 8'h30, 32'h0, 4'h0);
        begin
            int g = 0;
            while (!rready && g < 20) begin @(negedge ap_clk); g++; end
        end
        chk("t6_in_rd_d", rready, 1);
        ap_rst_n = 0;
        #1;
        chk("t6_rst_ctrl", {cmd_ready, busy, rready, arvalid, rsp_valid, awvalid, wvalid,
                            bready, rsp_timeout}, 0);
        chk("t6_rst_bus", {araddr, rsp_data, rsp_resp}, 0);
        @(negedge ap_clk);
        ap_rst_n = 1;
        #1;
        chk("t6_rel_cmd_ready", cmd_ready, 1);
        @(negedge ap_clk);
        set_delays(0, 0, 0, 1, 2);
        send_cmd(0, 8'h30, 32'h0, 4'h0);
        wait_rsp();
        chk("t6_after_data", o_data, rmem[12]);
        chk("t6_after_lat", lat, 6);

        // Random traffic against the word-memory model.
        for (int n = 0; n < 24; n++) begin
            wr = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 8'hBF));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3));
            cfg_resp = 2'($urandom_range(0, 3));
            send_cmd(wr, a, d, s);
            if (wr) ref_write(a, d, s);
            wait_rsp();
            chk("rnd_resp", {o_to, o_resp}, {1'b0, cfg_resp});
            if (wr) begin
                mx = (aw_d > w_d) ? aw_d : w_d;
                chk("rnd_wr_data", o_data, 0);
                chk("rnd_wr_beats", {aw_beats[7:0], w_beats[7:0]}, 16'h0101);
                chk("rnd_wr_bus", {aw_rec, ws_rec}, {a[7:2], 2'b00, s});
                chk("rnd_wr_lat", lat, mx + b_d + 3);
            end else begin
                chk("rnd_rd_data", o_data, rmem[a[7:2]]);
                chk("rnd_rd_beats", ar_beats, 1);
                chk("rnd_rd_lat", lat, ar_d + r_d + 3);
            end
        end
        for (int i = 0; i < 48; i++) chk("mem_final", smem[i], rmem[i]);
        chk("bus_stable", stab_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
